// File: rtl/serial_adder_unit.sv
// serial_adder_unit: bit-serial adder/subtractor, LSB first, one full-adder
// stage shared across WIDTH clock cycles. Control is an IDLE/SHIFT/DONE FSM
// with registered Busy/Done. A subtract is done as A + ~B + 1; the +1 comes
// from seeding the carry flop with Sub.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output V. Without the macro, V and its logic are absent.
module serial_adder_unit #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;      // latched A, shifted right one bit per cycle
  logic [WIDTH-1:0] b_q;      // latched B (pre-inverted for subtract), shifted likewise
  logic [CW-1:0]    cnt_q;    // index of the bit being produced
  logic             carry_q;  // carry between bit-cycles
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             v_q;
`endif

  logic sum_d;
  logic cy_d;

  // The single full-adder stage working on the current LSBs and the carry flop.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    sum_d = a_q[0] ^ b_q[0] ^ carry_q;
    cy_d  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  end

  // FSM, datapath and registered outputs, with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge values of the others, whatever order the statements are in.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      // These are ordinary flops, not a memory array, so all of them reset.
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        // DONE behaves like IDLE for Start, which allows back-to-back operations.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (Start) begin
            a_q     <= A;
            b_q     <= Sub ? ~B : B;
            carry_q <= Sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        SHIFT: begin
          s_q[cnt_q] <= sum_d;
          carry_q    <= cy_d;
          a_q        <= a_q >> 1;
          b_q        <= b_q >> 1;
          if (cnt_q == LAST_BIT) begin
            // carry_q is the carry into the MSB here, cy_d the carry out of it.
            cout_q  <= cy_d;
`ifdef SERIAL_ADDER_OVF_EN
            v_q     <= carry_q ^ cy_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign S     = s_q;
  assign C_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign V     = v_q;
`endif

endmodule

// File: tb/tb_serial_adder_unit.sv
// Self-checking bench for serial_adder_unit (WIDTH=8). Expected results come
// from integer arithmetic on the operands; timing expectations come from the
// Start-to-Done latency of WIDTH+1 cycles.
module tb_serial_adder_unit;

  localparam int W = 8;
  localparam longint unsigned MASK = (64'd1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         v;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Last result the DUT should be holding.
  logic [W-1:0] last_s = '0;
  logic         last_c = 1'b0;
  logic         last_v = 1'b0;

  serial_adder_unit #(.WIDTH(W)) dut (
    .Clock (clk),
    .Resetn(rst_n),
    .Start (start),
    .Sub   (sub),
    .A     (a),
    .B     (b),
    .Busy  (busy),
    .Done  (done),
    .S     (s),
    .C_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .V     (v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the operand values.
  task automatic model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic is_sub,
                       output logic [W-1:0] es, output logic ec, output logic ev);
    longint sa, sb, sr;
    longint unsigned ua, ub;
    ua = longint'(ai);
    ub = longint'(bi);
    sa = ai[W-1] ? longint'(ua) - (longint'(1) << W) : longint'(ua);
    sb = bi[W-1] ? longint'(ub) - (longint'(1) << W) : longint'(ub);
    if (is_sub) begin
      es = W'((ua - ub) & MASK);
      ec = (ua >= ub);       // carry out of a subtract means "no borrow"
      sr = sa - sb;
    end else begin
      es = W'((ua + ub) & MASK);
      ec = ((ua + ub) >> W) != 0;
      sr = sa + sb;
    end
    ev = (sr > (longint'(1) << (W - 1)) - 1) || (sr < -(longint'(1) << (W - 1)));
  endtask

  // Start one operation and follow it to Done. With noise set, Start/Sub/A/B
  // keep changing during the shift phase and must be ignored. Returns in the
  // Done cycle; calling again immediately gives a back-to-back start.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic is_sub, input bit noise);
    logic [W-1:0] es;
    logic ec, ev;
    model(ai, bi, is_sub, es, ec, ev);
    start = 1'b1;
    a     = ai;
    b     = bi;
    sub   = is_sub;
    step();
    check("busy_after_start", busy, 1'b1);
    check("done_after_start", done, 1'b0);
    if (!noise) start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      if (noise) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
      end
      step();
      if (i < W) begin
        check("busy_shift", busy, 1'b1);
        check("done_shift", done, 1'b0);
      end else begin
        check("done_pulse", done, 1'b1);
        check("busy_in_done", busy, 1'b0);
        check("s_result", s, es);
        check("c_out_result", c_out, ec);
`ifdef SERIAL_ADDER_OVF_EN
        check("v_result", v, ev);
`endif
      end
    end
    last_s = es;
    last_c = ec;
    last_v = ev;
    start  = 1'b0;
    sub    = 1'b0;
  endtask

  // Idle cycles with wandering operands: Done must drop and results must hold.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      step();
      check("done_idle", done, 1'b0);
      check("busy_idle", busy, 1'b0);
      check("s_hold", s, last_s);
      check("c_out_hold", c_out, last_c);
`ifdef SERIAL_ADDER_OVF_EN
      check("v_hold", v, last_v);
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;      // Start during reset must be ignored
    sub   = 1'b0;
    a     = 8'hFF;
    b     = 8'h01;
    step();
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_s", s, 8'h00);
    check("rst_c_out", c_out, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_v", v, 1'b0);
`endif
    rst_n = 1'b1;
    start = 1'b0;
    idle(2);

    // Directed vectors
    run_op(8'h35, 8'h0C, 1'b0, 1'b0);   // 0x41, no carry
    idle(2);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);   // wraps to 0x00, carry out
    run_op(8'h05, 8'h07, 1'b1, 1'b0);   // back-to-back: 0xFE, borrow
    idle(1);
    run_op(8'h80, 8'h01, 1'b1, 1'b1);   // 0x7F, signed overflow, noisy inputs
    idle(1);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);   // 0x80, signed overflow on add
    idle(1);

    // Reset during the shift phase aborts the operation without a Done pulse.
    start = 1'b1;
    a     = 8'hA5;
    b     = 8'h3C;
    sub   = 1'b0;
    step();
    start = 1'b0;
    repeat (4) step();                  // bits 0..3 done, bit 4 is next
    rst_n = 1'b0;
    start = 1'b1;
    step();
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_s", s, 8'h00);
    check("abort_c_out", c_out, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check("abort_v", v, 1'b0);
`endif
    rst_n  = 1'b1;
    start  = 1'b0;
    last_s = '0;
    last_c = 1'b0;
    last_v = 1'b0;
    idle(W + 2);                        // no late Done from the aborted operation
    run_op(8'h12, 8'h34, 1'b0, 1'b0);
    idle(1);

    // Randomized operations, mixing idle gaps, back-to-back starts and noise.
    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
